// File: rtl/gate_arbiter_if.sv
// Request/response bundle between the two requesters and gate_arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface gate_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready
  );
endinterface

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Exactly one operation is in flight: IDLE accepts, EXEC computes, RESP
// presents the result to the owning requester until it is consumed.
module gate_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  gate_arbiter_if.slave  bus,
  output logic           busy,
  output logic           grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic             grant0, grant1, accept, rsp_fire;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;

  function automatic logic [WIDTH-1:0] gate_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   gate_op = a & b;
      2'b01:   gate_op = a | b;
      2'b10:   gate_op = a ^ b;
      default: gate_op = ~(a ^ b);
    endcase
  endfunction

  // Grant, handshake and next-state decode; prio only breaks ties.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    rsp_fire  = 1'b0;
    if (state == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
      grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
    end
    accept = grant0 || grant1;
    if (state == RESP)
      rsp_fire = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: only the owning response channel ever shows valid.
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rsp0_valid = (state == RESP) && !grant_id;
    bus.rsp1_valid = (state == RESP) &&  grant_id;
    bus.rsp0_data  = result_reg;
    bus.rsp1_data  = result_reg;
    busy           = (state != IDLE);
  end

  // Control state: FSM, owner of the transaction and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        grant_id <= grant1;
      if (rsp_fire)
        prio <= ~grant_id;
    end
  end

  // Operand capture on the accept edge only; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg <= grant1 ? bus.req1_op : bus.req0_op;
      a_reg  <= grant1 ? bus.req1_a  : bus.req0_a;
      b_reg  <= grant1 ? bus.req1_b  : bus.req0_b;
    end
  end

  // Result register: written once in EXEC, held through any back-pressure.
  always_ff @(posedge clk) begin
    if (rst)
      result_reg <= '0;
    else if (state == EXEC)
      result_reg <= gate_op(op_reg, a_reg, b_reg);
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter: single op, op table, contention,
// back-pressure, operand stability and reset while a response is pending.
module tb_gate_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic grant_id;
  int   n_cmp = 0;
  int   n_bad = 0;

  gate_arbiter_if #(.WIDTH(16)) bus ();

  gate_arbiter #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Advance one clock and step just past the edge before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp0_valid got=%b want=0", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp1_valid got=%b want=0", bus.rsp1_valid); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_grant_id got=%b want=0", grant_id); end
    n_cmp++; if (bus.rsp0_data !== 16'h0000) begin n_bad++; $display("FAIL reset_result got=%h want=0000", bus.rsp0_data); end
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready got=%b want=0", bus.req0_ready); end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 16'hF0F0; bus.req0_b = 16'hFF00;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_req0_ready got=%b want=1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL single_req1_ready got=%b want=0", bus.req1_ready); end
    tick();
    bus.req0_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_exec got=%b want=1", busy); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp0_early got=%b want=0", bus.rsp0_valid); end
    tick();
    n_cmp++; if (bus.rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp0_valid got=%b want=1", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp0_data !== 16'hF000) begin n_bad++; $display("FAIL single_data got=%h want=f000", bus.rsp0_data); end
    n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp1_valid got=%b want=0", bus.rsp1_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_resp got=%b want=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_done got=%b want=0", busy); end
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp0_done got=%b want=0", bus.rsp0_valid); end
  endtask

  task automatic test_all_ops();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h000F; exp_tab[1] = 16'h0FFF; exp_tab[2] = 16'h0FF0; exp_tab[3] = 16'hF00F;
    for (int i = 0; i < 4; i++) begin
      bus.req1_valid = 1'b1; bus.req1_op = 2'(i); bus.req1_a = 16'h00FF; bus.req1_b = 16'h0F0F;
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++; $display("FAIL ops_req1_ready op=%0d got=%b want=1", i, bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      tick();
      n_cmp++; if (bus.rsp1_valid !== 1'b1) begin n_bad++; $display("FAIL ops_rsp1_valid op=%0d got=%b want=1", i, bus.rsp1_valid); end
      n_cmp++; if (bus.rsp1_data !== exp_tab[i]) begin n_bad++; $display("FAIL ops_data op=%0d got=%h want=%h", i, bus.rsp1_data, exp_tab[i]); end
      n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL ops_rsp0_valid op=%0d got=%b want=0", i, bus.rsp0_valid); end
      tick();
    end
  endtask

  task automatic test_contention();
    logic        g;
    logic [15:0] want;
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 16'h1234; bus.req0_b = 16'h00FF;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_a = 16'hAAAA; bus.req1_b = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      g    = (i % 2) == 1;
      want = g ? 16'hFFFF : 16'h12CB;
      #1;
      n_cmp++; if (bus.req0_ready !== !g) begin n_bad++; $display("FAIL cont_req0_ready op=%0d got=%b want=%b", i, bus.req0_ready, !g); end
      n_cmp++; if (bus.req1_ready !== g) begin n_bad++; $display("FAIL cont_req1_ready op=%0d got=%b want=%b", i, bus.req1_ready, g); end
      tick(); tick();
      n_cmp++; if (grant_id !== g) begin n_bad++; $display("FAIL cont_grant_id op=%0d got=%b want=%b", i, grant_id, g); end
      n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== (g ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL cont_rsp_valid op=%0d got=%b%b", i, bus.rsp1_valid, bus.rsp0_valid); end
      n_cmp++; if ((g ? bus.rsp1_data : bus.rsp0_data) !== want) begin n_bad++; $display("FAIL cont_data op=%0d got=%h want=%h", i, g ? bus.rsp1_data : bus.rsp0_data, want); end
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h1357;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 16'h0000; bus.req1_b = 16'h0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp0_valid cyc=%0d got=%b want=1", i, bus.rsp0_valid); end
      n_cmp++; if (bus.rsp0_data !== 16'h1357) begin n_bad++; $display("FAIL bp_data cyc=%0d got=%h want=1357", i, bus.rsp0_data); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_req_ready cyc=%0d got=%b%b want=00", i, bus.req1_ready, bus.req0_ready); end
      n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL bp_rsp1_valid cyc=%0d got=%b want=0", i, bus.rsp1_valid); end
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req1_early got=%b want=0", bus.req1_ready); end
    tick();
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_req1_after got=%b want=1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++; if (bus.rsp1_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp1_after got=%b want=1", bus.rsp1_valid); end
    n_cmp++; if (bus.rsp1_data !== 16'hFFFF) begin n_bad++; $display("FAIL bp_rsp1_data got=%h want=ffff", bus.rsp1_data); end
    tick();
  endtask

  task automatic test_operand_change();
    bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 16'h0F00; bus.req0_b = 16'h00F0;
    tick();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b11; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h1111;
    tick();
    n_cmp++; if (bus.rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL opchg_rsp0_valid got=%b want=1", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp0_data !== 16'h0FF0) begin n_bad++; $display("FAIL opchg_data got=%h want=0ff0", bus.rsp0_data); end
    tick();
  endtask

  task automatic test_reset_resp();
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 16'hFFFF; bus.req1_b = 16'hFFFF;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++; if (bus.rsp1_valid !== 1'b1) begin n_bad++; $display("FAIL rstresp_pre got=%b want=1", bus.rsp1_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL rstresp_rsp1_valid got=%b want=0", bus.rsp1_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstresp_busy got=%b want=0", busy); end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL rstresp_req0_ready got=%b want=1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL rstresp_req1_ready got=%b want=0", bus.req1_ready); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_all_ops();
    test_contention();
    test_back_pressure();
    test_operand_change();
    test_reset_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
